reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised register file with two combinational read ports and two clocked write ports.
  - Write port 3: main single-cycle writeback.
  - Write port 4: late writeback from multicycle units, for example mult/div or a slow load path.
- Holds a per-register pending (scoreboard) bit and a pending-count counter. Decode uses these to stall on RAW hazards against in-flight long-latency ops.
- Sits between decode and writeback in the MIPS datapath.
- Replaces the fixed 32x32 file with a resettable, bypassing, hazard-aware one.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never pending
- BYPASS, 1, 1: a same-cycle write is forwarded to the read ports (write-first); 0: reads return the stored value only

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- A1  in  ADDR_W  read address, port 1
- A2  in  ADDR_W  read address, port 2
- RD1  out  DATA_W  read data, port 1
- RD2  out  DATA_W  read data, port 2
- BUSY1  out  1  pending bit of A1
- BUSY2  out  1  pending bit of A2
- WE3  in  1  write enable, main port
- A3  in  ADDR_W  write address, main port
- WD3  in  DATA_W  write data, main port
- WE4  in  1  write enable, late port; also clears the pending bit of A4
- A4  in  ADDR_W  write address, late port
- WD4  in  DATA_W  write data, late port
- SET_EN  in  1  mark register SET_A pending (long-latency op issued)
- SET_A  in  ADDR_W  register to mark pending
- PEND_CNT  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst=1, asynchronous, effective immediately and independent of clk):
  - All registers go to 0.
  - All pending bits go to 0.
  - PEND_CNT goes to 0.
  - Hence RD1=RD2=0 and BUSY1=BUSY2=0 while rst is held.
  - Reset asserted mid-operation discards any write or set in that cycle.
- Reads are combinational with zero latency.
  - RDn = mem[An]; BUSYn = pend[An].
- Writes take effect at the rising edge and are visible to reads in the following cycle.
- Same-address write collision:
  - WE3 and WE4 both asserted with A3==A4: WD4 is stored; port 4 has priority.
  - Different addresses: both writes land.
- Bypass (BYPASS=1):
  - If WE4 and A4==An, then RDn = WD4.
  - Else if WE3 and A3==An, then RDn = WD3.
  - Else RDn = mem[An].
  - BUSYn is not bypassed; it is the registered pending bit.
- Scoreboard, per register r, at the clock edge:
  - set_r = SET_EN and SET_A==r.
  - clr_r = WE4 and A4==r.
  - set_r wins over clr_r, so a new issue overrides the retiring op.
  - Otherwise set_r forces 1, clr_r forces 0, and neither holds the value.
  - WE3 does not affect pending bits.
- PEND_CNT:
  - Registered; equals the population count of the next-state pending vector.
  - Changes by -1, 0 or +1 per cycle. It can never exceed 2**ADDR_W, and with ZERO_REG=1 it can never exceed 2**ADDR_W-1.
  - Setting an already-pending register does not change the count.
  - Clearing an already-clear register does not change the count.
- ZERO_REG=1:
  - Writes to address 0 on either port are dropped.
  - SET_A=0 is ignored.
  - RDn=0 and BUSYn=0 whenever An=0, including bypass cases.
- ZERO_REG=0: register 0 is an ordinary register.
- No X propagation: disabled ports ignore address and data values.

Test Plan:
- Reset: hold rst with random writes and sets asserted, then release -> all 32 registers read 0, BUSY1=BUSY2=0, PEND_CNT=0. Assert rst mid-cycle after writing R5=0x1234 -> RD(A=5) reads 0 immediately, before any clock edge.
- Write/read with BYPASS=1: WE3=1, A3=7, WD3=0xDEADBEEF, A1=7 in the same cycle -> RD1=0xDEADBEEF combinationally. Next cycle with WE3=0 -> RD1 still 0xDEADBEEF. With BYPASS=0 -> RD1 shows the old value 0 until after the edge.
- Collision: WE3=WE4=1, A3=A4=9, WD3=0x1111, WD4=0x2222 -> RD of 9 is 0x2222 in the same cycle (bypass) and after the edge.
- Zero register: WE3=1, A3=0, WD3=0xFFFFFFFF, and SET_EN=1, SET_A=0 -> RD1 (A1=0) is 0 and BUSY1=0, and PEND_CNT stays 0.
- Scoreboard:
  - Cycle 1: SET_EN with SET_A=3 -> BUSY1 (A1=3)=1, PEND_CNT=1.
  - Cycle 2: SET_A=4 -> PEND_CNT=2.
  - Cycle 3: WE4, A4=3, WD4=0x55 -> BUSY1=0, RD1=0x55, PEND_CNT=1.
  - Then SET_EN with SET_A=4 together with WE4, A4=4 -> BUSY(4) stays 1, PEND_CNT stays 1.
- Full and idempotent: set registers 1..31 in consecutive cycles -> PEND_CNT reaches 31. Re-set register 10 -> PEND_CNT stays 31. Clear register 10 twice via WE4 -> PEND_CNT goes 30, then stays 30.

Source files
------------

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with per-register pending bits for RAW-hazard stalls
// on long-latency ops. Port 4 (late writeback) wins collisions and retires pending bits.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE4,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              SET_EN,
  input  logic [ADDR_W-1:0] SET_A,
  output logic [ADDR_W:0]   PEND_CNT
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic we3_ok, we4_ok, set_ok;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];

  // Register 0 is hardwired: drop writes and sets to it at the source.
  assign we3_ok = WE3 && !(ZERO_REG != 0 && A3 == '0);
  assign we4_ok = WE4 && !(ZERO_REG != 0 && A4 == '0);
  assign set_ok = SET_EN && !(ZERO_REG != 0 && SET_A == '0);

  // Later assignment wins, so port 4 overrides port 3 on a shared address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < Depth; r++) mem_q[r] <= '0;
    end else begin
      if (we3_ok) mem_q[A3] <= WD3;
      if (we4_ok) mem_q[A4] <= WD4;
    end
  end

  // A new issue overrides a retiring op on the same register.
  always_comb begin
    pend_d = pend_q;
    if (we4_ok) pend_d[A4] = 1'b0;
    if (set_ok) pend_d[SET_A] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < Depth; r++) cnt_d = cnt_d + (ADDR_W + 1)'(pend_d[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ra[0] = A1;
  assign ra[1] = A2;

  // Bypass is gated by rst so reads show zero for the whole reset window.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = mem_q[ra[p]];
      if (BYPASS != 0 && !rst) begin
        if (we3_ok && A3 == ra[p]) rd[p] = WD3;
        if (we4_ok && A4 == ra[p]) rd[p] = WD4;
      end
      if (ZERO_REG != 0 && ra[p] == '0) rd[p] = '0;
    end
  end

  assign RD1      = rd[0];
  assign RD2      = rd[1];
  assign BUSY1    = pend_q[A1];
  assign BUSY2    = pend_q[A2];
  assign PEND_CNT = cnt_q;

endmodule
